// File: rtl/frame_buffer_reader_pkg.sv
// Shared definitions for the frame buffer reader.
// Contents: FSM state encoding, custom-instruction opcodes, control codes,
// bus constants and the burst-length helper.
package frame_buffer_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEGIN = 3'd2,
    ST_DATA  = 3'd3,
    ST_ABORT = 3'd4,
    ST_NEXT  = 3'd5
  } state_t;

  localparam logic [2:0] CI_RD_BASE   = 3'd0;
  localparam logic [2:0] CI_WR_BASE   = 3'd1;
  localparam logic [2:0] CI_WR_WPL    = 3'd2;
  localparam logic [2:0] CI_WR_LPF    = 3'd3;
  localparam logic [2:0] CI_CTRL      = 3'd4;
  localparam logic [2:0] CI_RD_STATUS = 3'd5;
  localparam logic [2:0] CI_RD_LINE   = 3'd6;
  localparam logic [2:0] CI_RD_ZERO   = 3'd7;

  localparam logic [1:0] CTRL_STOP   = 2'b00;
  localparam logic [1:0] CTRL_CONT   = 2'b01;
  localparam logic [1:0] CTRL_SINGLE = 2'b10;
  localparam logic [1:0] CTRL_NOP    = 2'b11;

  localparam int         MAX_BURST = 16;
  localparam logic [3:0] BE_ALL    = 4'hF;

  // Words in the next burst: the rest of the line, capped at the burst limit.
  function automatic logic [8:0] burst_len(input logic [8:0] remaining,
                                           input logic [8:0] limit);
    return (remaining > limit) ? limit : remaining;
  endfunction

endpackage

// File: rtl/frame_buffer_reader_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy-derived free count.
// Ports:
//   clock, reset        - rising-edge clock, async active-low reset
//   push_i, push_data_i - write strobe and data
//   pop_i, head_o       - read strobe and head-of-queue data (show-ahead)
//   full_o, empty_o     - status flags
//   free_o              - number of free entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   free_o
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign free_o  = DEPTH_CNT - count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The reader reserves space before every burst, so this must never fire.
  always_ff @(posedge clock) begin
    if (reset) assert (!(push_i && full_o));
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: burst-read DMA that streams a frame buffer out as
// 32-bit words on a valid/ready interface.
// Ports:
//   clock, reset           - system clock, async active-low reset
//   ci*                    - custom-instruction config/status port
//   requestBus/busGrant    - bus arbitration
//   *Out (bus)             - burst read request, driven only in begin cycle
//   addressDataIn etc.     - read data / burst end / error from slave
//   pixelWord/Valid/First  - output stream (FIFO head), pixelReady pops
module frame_buffer_reader
  import frame_buffer_reader_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         fifoDepthLog2       = 5,
  parameter int         maxBurst            = MAX_BURST
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        requestBus,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic        readNotWriteOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        endTransactionOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  output logic [31:0] pixelWord,
  output logic        pixelValid,
  output logic        pixelFirst,
  input  logic        pixelReady
);

  localparam logic [8:0]             BURST_LIM   = 9'(maxBurst);
  localparam logic [fifoDepthLog2:0] BURST_SPACE = (fifoDepthLog2 + 1)'(maxBurst);

  state_t      state_q;
  logic [31:0] base_q, cur_addr_q, addr_out_q;
  logic [8:0]  wpl_q, remaining_q;
  logic [9:0]  lpf_q, line_q;
  logic        run_q, single_q, frame_done_q, error_q, first_pending_q;
  logic        req_q, begin_q, end_q;
  logic [7:0]  burst_size_q;

  logic                   sel, busy, start_ok;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [fifoDepthLog2:0] fifo_free;
  logic [32:0]            fifo_head;
  logic [8:0]             burst_n;
  logic [9:0]             line_next;
  logic                   unused_bits;

  assign sel       = ciStart & ciCke & (ciN == customInstructionId);
  assign ciDone    = sel;
  assign busy      = (state_q != ST_IDLE) | run_q | single_q;
  assign start_ok  = (wpl_q != '0) & (lpf_q != '0) & ~busy;
  assign burst_n   = burst_len(remaining_q, BURST_LIM);
  assign line_next = line_q + 10'd1;

  always_comb begin
    ciResult = '0;
    if (sel) begin
      case (ciValueA[2:0])
        CI_RD_BASE:   ciResult = base_q;
        CI_RD_STATUS: ciResult = {29'd0, error_q, frame_done_q, busy};
        CI_RD_LINE:   ciResult = {22'd0, line_q};
        default:      ciResult = '0;
      endcase
    end
  end

  // Beats beyond the programmed line length are dropped (and flagged below).
  assign fifo_push = (state_q == ST_DATA) & dataValidIn & (remaining_q != '0);
  assign fifo_pop  = pixelValid & pixelReady;

  sync_fifo #(.WIDTH(33), .DEPTH_LOG2(fifoDepthLog2)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (fifo_push),
    .push_data_i({first_pending_q, addressDataIn}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .free_o     (fifo_free)
  );

  assign pixelValid = ~fifo_empty;
  assign pixelWord  = fifo_empty ? 32'd0 : fifo_head[31:0];
  assign pixelFirst = ~fifo_empty & fifo_head[32];

  assign requestBus          = req_q;
  assign beginTransactionOut = begin_q;
  assign readNotWriteOut     = begin_q;
  assign byteEnablesOut      = {4{begin_q}} & BE_ALL;
  assign addressDataOut      = addr_out_q;
  assign burstSizeOut        = burst_size_q;
  assign endTransactionOut   = end_q;

  assign unused_bits = ^{ciValueA[31:3], ciValueB[31:10], fifo_full};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      cur_addr_q      <= '0;
      addr_out_q      <= '0;
      wpl_q           <= '0;
      remaining_q     <= '0;
      lpf_q           <= '0;
      line_q          <= '0;
      run_q           <= 1'b0;
      single_q        <= 1'b0;
      frame_done_q    <= 1'b1;
      error_q         <= 1'b0;
      first_pending_q <= 1'b0;
      req_q           <= 1'b0;
      begin_q         <= 1'b0;
      end_q           <= 1'b0;
      burst_size_q    <= '0;
    end else begin
      begin_q      <= 1'b0;
      end_q        <= 1'b0;
      addr_out_q   <= '0;
      burst_size_q <= '0;

      if (sel) begin
        case (ciValueA[2:0])
          CI_WR_BASE: base_q <= {ciValueB[31:2], 2'b00};
          CI_WR_WPL:  wpl_q  <= ciValueB[8:0];
          CI_WR_LPF:  lpf_q  <= ciValueB[9:0];
          CI_CTRL: begin
            // Stop only clears the mode bits; a burst in flight still runs
            // to completion because IDLE is the only place new work starts.
            if (ciValueB[1:0] == CTRL_STOP) begin
              run_q    <= 1'b0;
              single_q <= 1'b0;
            end else if (ciValueB[1:0] != CTRL_NOP && start_ok) begin
              run_q           <= (ciValueB[1:0] == CTRL_CONT);
              single_q        <= (ciValueB[1:0] == CTRL_SINGLE);
              if (ciValueB[1:0] == CTRL_SINGLE) frame_done_q <= 1'b0;
              cur_addr_q      <= base_q;
              line_q          <= '0;
              remaining_q     <= wpl_q;
              first_pending_q <= 1'b1;
            end
          end
          CI_RD_STATUS: error_q <= 1'b0;
          default: ;
        endcase
      end

      // FSM updates come after the CI block so hardware events win over a
      // same-cycle status-read clear of errorSticky.
      case (state_q)
        ST_IDLE: begin
          if ((run_q | single_q) && fifo_free >= BURST_SPACE) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (busGrant) begin
            state_q      <= ST_BEGIN;
            req_q        <= 1'b0;
            begin_q      <= 1'b1;
            addr_out_q   <= cur_addr_q;
            burst_size_q <= 8'(burst_n - 9'd1);
          end
        end
        ST_BEGIN: state_q <= ST_DATA;
        ST_DATA: begin
          if (dataValidIn) begin
            if (remaining_q != '0) begin
              first_pending_q <= 1'b0;
              cur_addr_q      <= cur_addr_q + 32'd4;
              remaining_q     <= remaining_q - 9'd1;
            end else begin
              error_q <= 1'b1;
            end
          end
          if (busErrorIn) begin
            state_q <= ST_ABORT;
            end_q   <= 1'b1;
          end else if (endTransactionIn) begin
            state_q <= ST_NEXT;
          end
        end
        ST_ABORT: begin
          error_q  <= 1'b1;
          run_q    <= 1'b0;
          single_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        ST_NEXT: begin
          state_q <= ST_IDLE;
          if (remaining_q == '0) begin
            remaining_q <= wpl_q;
            if (line_next >= lpf_q) begin
              if (single_q) begin
                single_q     <= 1'b0;
                frame_done_q <= 1'b1;
                line_q       <= line_next;
              end else begin
                line_q          <= '0;
                cur_addr_q      <= base_q;
                first_pending_q <= 1'b1;
              end
            end else begin
              line_q <= line_next;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
module tb_frame_buffer_reader;

  logic        clock, reset;
  logic        ciStart, ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB, ciResult;
  logic        ciDone;
  logic        requestBus, busGrant, beginTransactionOut, readNotWriteOut;
  logic [31:0] addressDataOut, addressDataIn;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        endTransactionOut, dataValidIn, endTransactionIn, busErrorIn;
  logic [31:0] pixelWord;
  logic        pixelValid, pixelFirst, pixelReady;

  frame_buffer_reader dut (
    .clock(clock), .reset(reset),
    .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciResult(ciResult), .ciDone(ciDone),
    .requestBus(requestBus), .busGrant(busGrant),
    .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
    .readNotWriteOut(readNotWriteOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .endTransactionOut(endTransactionOut),
    .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
    .pixelWord(pixelWord), .pixelValid(pixelValid),
    .pixelFirst(pixelFirst), .pixelReady(pixelReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int n_begin = 0;
  int n_req_cyc = 0;
  int n_end_cyc = 0;
  bit err_armed = 1'b0;

  logic [39:0] exp_burst [$];  // {burstSize, address}
  logic [32:0] exp_pix   [$];  // {first, word}
  logic [39:0] eb;
  logic [32:0] ep;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame layout for base 0x1000, 20 words/line, 2 lines:
  // line 0 = 0x1000 (16 words) + 0x1040 (4); line 1 = 0x1050 (16) + 0x1090 (4).
  task automatic push_exp(input int n_bursts, input int n_words);
    logic [31:0] baddr [4];
    logic [7:0]  bsize [4];
    baddr = '{32'h1000, 32'h1040, 32'h1050, 32'h1090};
    bsize = '{8'd15, 8'd3, 8'd15, 8'd3};
    for (int i = 0; i < n_bursts; i++) exp_burst.push_back({bsize[i % 4], baddr[i % 4]});
    for (int i = 0; i < n_words; i++)
      exp_pix.push_back({((i % 40) == 0), 32'h1000 + 32'((i % 40) * 4)});
  endtask

  task automatic ci(input logic [7:0] n, input logic [2:0] op, input logic [31:0] b,
                    output logic [31:0] r, output logic d);
    @(posedge clock); #1;
    ciStart = 1'b1; ciCke = 1'b1; ciN = n;
    ciValueA = {29'd0, op}; ciValueB = b;
    @(negedge clock);
    r = ciResult; d = ciDone;
    @(posedge clock); #1;
    ciStart = 1'b0; ciCke = 1'b0; ciValueA = '0; ciValueB = '0; ciN = '0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int k;
    k = 0;
    while ((exp_pix.size() != 0 || exp_burst.size() != 0) && k < budget) begin
      @(posedge clock);
      k++;
    end
    check(nm, 64'(exp_pix.size() + exp_burst.size()), 64'd0);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a burst or a word.
  always @(negedge clock) begin
    if (reset) begin
      if (requestBus) n_req_cyc++;
      if (endTransactionOut) n_end_cyc++;
      if (beginTransactionOut) begin
        n_begin++;
        if (exp_burst.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL burst_unexpected: got addr %0h size %0d, none expected",
                   addressDataOut, burstSizeOut);
        end else begin
          eb = exp_burst.pop_front();
          check("burst_addr", 64'(addressDataOut), 64'(eb[31:0]));
          check("burst_size", 64'(burstSizeOut), 64'(eb[39:32]));
          check("burst_rnw_be", 64'({readNotWriteOut, byteEnablesOut}), 64'h1F);
        end
      end
      if (pixelValid && pixelReady) begin
        if (exp_pix.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL pixel_unexpected: got first %0b word %0h, none expected",
                   pixelFirst, pixelWord);
        end else begin
          ep = exp_pix.pop_front();
          check("pixel", 64'({pixelFirst, pixelWord}), 64'(ep));
        end
      end
    end
  end

  // Slave: grants immediately, then returns memory[a] = a for each beat.
  int          sl_n;
  logic [31:0] sl_addr;
  initial begin
    busGrant = 1'b0; dataValidIn = 1'b0; endTransactionIn = 1'b0;
    busErrorIn = 1'b0; addressDataIn = '0;
    forever begin
      @(posedge clock); #1;
      busGrant = requestBus;
      if (beginTransactionOut) begin
        busGrant = 1'b0;
        sl_addr = addressDataOut;
        sl_n = int'(burstSizeOut) + 1;
        @(posedge clock); #1;
        for (int i = 0; i < sl_n; i++) begin
          if (err_armed && i == 2) begin
            err_armed = 1'b0;
            dataValidIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b1;
            @(posedge clock); #1;
            busErrorIn = 1'b0;
            break;
          end
          dataValidIn = 1'b1;
          addressDataIn = sl_addr + 32'(4 * i);
          endTransactionIn = (i == sl_n - 1);
          @(posedge clock); #1;
        end
        dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        d;
    int          k, b0, q0, e0;

    reset = 1'b0; ciStart = 1'b0; ciCke = 1'b0; ciN = '0;
    ciValueA = '0; ciValueB = '0; pixelReady = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_bus_ctrl", 64'({requestBus, beginTransactionOut, readNotWriteOut,
                               endTransactionOut, byteEnablesOut, burstSizeOut}), 64'd0);
    check("rst_bus_addr", 64'(addressDataOut), 64'd0);
    check("rst_pixel", 64'({pixelValid, pixelFirst, pixelWord}), 64'd0);
    check("rst_ci", 64'({ciDone, ciResult}), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    ci(8'd0, 3'd5, 32'd0, r, d);
    check("status_after_reset", 64'(r), 64'h2);
    check("ci_done_selected", 64'(d), 64'd1);
    ci(8'd3, 3'd0, 32'd0, r, d);
    check("ci_unselected", 64'({d, r}), 64'd0);

    // Single frame, consumer always ready.
    ci(8'd0, 3'd1, 32'h1003, r, d);
    ci(8'd0, 3'd0, 32'd0, r, d);
    check("base_aligned", 64'(r), 64'h1000);
    ci(8'd0, 3'd2, 32'd20, r, d);
    ci(8'd0, 3'd3, 32'd2, r, d);
    pixelReady = 1'b1;
    push_exp(4, 40);
    ci(8'd0, 3'd4, 32'd2, r, d);
    wait_drain("single_drain", 2000);
    repeat (5) @(posedge clock);
    ci(8'd0, 3'd5, 32'd0, r, d);
    check("single_status", 64'(r), 64'h2);
    ci(8'd0, 3'd6, 32'd0, r, d);
    check("single_line", 64'(r), 64'd2);
    ci(8'd0, 3'd7, 32'd0, r, d);
    check("op7_zero", 64'(r), 64'd0);

    // Consumer stalled: 16 + 4 words fetched, then 12 free < 16 blocks requests.
    pixelReady = 1'b0;
    b0 = n_begin;
    push_exp(4, 40);
    ci(8'd0, 3'd4, 32'd2, r, d);
    repeat (80) @(posedge clock);
    q0 = n_req_cyc;
    repeat (100) @(posedge clock);
    #1;
    check("stall_bursts", 64'(n_begin - b0), 64'd2);
    check("stall_no_req", 64'(n_req_cyc - q0), 64'd0);
    check("stall_valid", 64'(pixelValid), 64'd1);
    pixelReady = 1'b1;
    wait_drain("stall_drain", 2000);
    repeat (5) @(posedge clock);
    ci(8'd0, 3'd5, 32'd0, r, d);
    check("stall_status", 64'(r), 64'h2);

    // Continuous: frame wraps to base with first flag; stop during burst 7.
    b0 = n_begin;
    push_exp(7, 76);
    ci(8'd0, 3'd4, 32'd1, r, d);
    k = 0;
    while (n_begin < b0 + 7 && k < 3000) begin
      @(posedge clock);
      k++;
    end
    check("cont_reach_burst7", 64'(n_begin - b0), 64'd7);
    ci(8'd0, 3'd4, 32'd0, r, d);
    wait_drain("cont_drain", 2000);
    q0 = n_req_cyc;
    repeat (60) @(posedge clock);
    #1;
    check("stop_no_req", 64'(n_req_cyc - q0), 64'd0);
    ci(8'd0, 3'd5, 32'd0, r, d);
    check("stop_not_busy", 64'(r & 32'h1), 64'd0);

    // Bus error on the third beat of the first burst.
    e0 = n_end_cyc;
    err_armed = 1'b1;
    push_exp(1, 2);
    ci(8'd0, 3'd4, 32'd2, r, d);
    wait_drain("err_drain", 500);
    repeat (10) @(posedge clock);
    #1;
    check("err_end_pulse", 64'(n_end_cyc - e0), 64'd1);
    ci(8'd0, 3'd5, 32'd0, r, d);
    check("err_status_first", 64'(r), 64'h4);
    ci(8'd0, 3'd5, 32'd0, r, d);
    check("err_status_second", 64'(r), 64'h0);

    // Start with zero words per line must be ignored.
    ci(8'd0, 3'd2, 32'd0, r, d);
    q0 = n_req_cyc;
    ci(8'd0, 3'd4, 32'd2, r, d);
    repeat (30) @(posedge clock);
    #1;
    check("zero_wpl_no_req", 64'(n_req_cyc - q0), 64'd0);
    ci(8'd0, 3'd5, 32'd0, r, d);
    check("zero_wpl_status", 64'(r), 64'h0);

    repeat (5) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
